s2mm_packet_arbiter: RTL
========================

Name: s2mm_packet_arbiter

Overview:
- Merges NUM_FIFOS accelerator output FIFOs into one AXI Stream for the slave S2MM port of the MCDMA.
- Tags each packet with its source FIFO index on tdest and generates tlast from a configured packet length.
- Packets are never interleaved: a source is locked from first to last beat.
- Round-robin arbitration between packets gives every source fair access.

Parameters:
- AXIS_DATA_WIDTH, 32, output stream data width; must be ≥ FIFO_DATA_WIDTH.
- FIFO_DATA_WIDTH, 32, per-FIFO data width.
- AXIS_DEST_WIDTH, 4, tdest width; 2^AXIS_DEST_WIDTH ≥ NUM_FIFOS.
- NUM_FIFOS, 2, number of source FIFOs.
- PKT_LEN_WIDTH, 16, width of the packet-length and beat counters.

Ports:
- clk  in  1  single clock for all logic.
- rstn  in  1  asynchronous, active-low reset.
- fifo_rden_out  out  NUM_FIFOS  per-FIFO read enable (pop).
- fifo_empty_in  in  NUM_FIFOS  per-FIFO empty flag.
- fifo_data_in  in  FIFO_DATA_WIDTH*NUM_FIFOS  FIFO i data on slice [(i+1)*FIFO_DATA_WIDTH-1 : i*FIFO_DATA_WIDTH]; first-word-fall-through.
- pkt_len_in  in  PKT_LEN_WIDTH  packet length in beats, shared by all sources; sampled at grant.
- DST_AXIS_tdata_out  out  AXIS_DATA_WIDTH  stream data; FIFO data zero-extended.
- DST_AXIS_tdest_out  out  AXIS_DEST_WIDTH  index of the source FIFO.
- DST_AXIS_tlast_out  out  1  last beat of a packet.
- DST_AXIS_tvalid_out  out  1  stream valid.
- DST_AXIS_tready_in  in  1  stream ready from the MCDMA.

Behaviour:
- Reset (async assert, sync release):
  - tvalid, tlast, tdata, tdest = 0; fifo_rden_out = 0.
  - State = IDLE, rr_ptr = 0, beat_cnt = 0.
  - A reset mid-packet discards the in-flight beat and the rest of the packet; no tlast is emitted for it.
- Output register: one entry.
  - out_free = !tvalid || tready.
  - A beat is transferred on the edge where tvalid && tready.
- IDLE:
  - Search for a non-empty FIFO starting at rr_ptr, wrapping modulo NUM_FIFOS.
  - If one is found: register grant = index, latch len = (pkt_len_in == 0 ? 1 : pkt_len_in), clear beat_cnt, go to XFER.
  - If none is found: stay in IDLE.
  - IDLE never pops a FIFO.
- XFER:
  - fifo_rden_out[grant] = out_free && !fifo_empty_in[grant]; all other rden bits are 0. The rden logic is combinational.
  - On a pop: load tdata ← FIFO data, tdest ← grant, tvalid ← 1, tlast ← (beat_cnt == len-1), then beat_cnt++.
  - After popping the last beat: state → IDLE, rr_ptr ← (grant+1) mod NUM_FIFOS.
  - If out_free and there is no pop, tvalid ← 0.
  - An empty locked FIFO mid-packet stalls the stream (tvalid drops); no other source is granted.
- Latency:
  - FIFO non-empty seen in IDLE at cycle N → grant at edge N+1 → pop in cycle N+1 → tvalid at edge N+2.
  - One bubble cycle per packet boundary.
  - Steady state: 1 beat/cycle while tready = 1 and the FIFO is non-empty.
- Backpressure: while tready = 0 with tvalid = 1, tdata/tdest/tlast/tvalid are held stable and no pop occurs.
- Simultaneous events: IDLE may re-arbitrate while the previous last beat is still held; the next packet's first pop waits for out_free.
- pkt_len_in changes mid-packet have no effect on the current packet.

Optional Feature:
- Macro: S2MM_PKT_COUNT_EN.
- With the macro defined:
  - Adds output pkt_count_out, width 32*NUM_FIFOS.
  - Per-source wrapping counters increment on the handshake of a tlast beat from that source.
  - Counters are cleared by reset.
- Without the macro: the port and counters are absent; all other behaviour is identical.

Decomposition:
- Shared package (s2mm_pkg):
  - State enum {IDLE, XFER}.
  - Function idx_width(NUM_FIFOS) returning clog2 with a minimum of 1.
  - Constant COUNT_WIDTH = 32.
- Sub-module rr_arbiter: combinational priority search from rr_ptr; outputs found and index.

Test Plan:
- Single source: NUM_FIFOS = 2, pkt_len = 4, FIFO0 holds 0xA0..0xA3, tready = 1 → 4 beats with tdest = 0 and tlast on 0xA3; first tvalid 2 cycles after empty deasserts.
- Round robin: both FIFOs hold 8 words, pkt_len = 4 → packets in order tdest 0,1,0,1, never interleaved; exactly 4 tlast pulses.
- Backpressure: tready toggles 1,0,0,1 mid-packet → outputs held stable during tready = 0; no extra fifo_rden_out pulses; data order preserved.
- Underflow stall: FIFO1 goes empty after 2 of 4 beats while FIFO0 is full → tvalid drops; no FIFO0 beat is sent until FIFO1 supplies beats 3–4 with tlast.
- pkt_len = 0 and an async reset asserted mid-packet → a length-0 packet is a 1-beat packet with tlast; after reset, tvalid = 0 immediately and the next packet starts from FIFO0.
- S2MM_PKT_COUNT_EN: 3 packets from FIFO0 and 2 from FIFO1 → pkt_count_out = {32'd2, 32'd3}.

Source files
------------

// File: rtl/s2mm_pkg.sv
// s2mm_pkg: shared definitions for the S2MM packet arbiter.
//   state_t     : arbiter state (IDLE searches for a source, XFER streams one packet).
//   idx_width() : bit width of a source index (clog2 of the source count, at least 1).
//   COUNT_WIDTH : width of each per-source packet counter (optional S2MM_PKT_COUNT_EN build).
package s2mm_pkg;

    typedef enum logic {
        IDLE,
        XFER
    } state_t;

    localparam int COUNT_WIDTH = 32;

    function automatic int idx_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/s2mm_packet_arbiter_rr_arbiter.sv
// rr_arbiter: combinational round-robin search.
//   req   in  NUM_FIFOS  request (non-empty) per source
//   ptr   in  IDX_W      source with highest priority this search
//   found out 1          at least one source requests
//   idx   out IDX_W      first requesting source at or after ptr, wrapping
module rr_arbiter #(
    parameter int NUM_FIFOS = 2,
    parameter int IDX_W     = 1
) (
    input  logic [NUM_FIFOS-1:0] req,
    input  logic [IDX_W-1:0]     ptr,
    output logic                 found,
    output logic [IDX_W-1:0]     idx
);

    localparam int unsigned N = NUM_FIFOS;

    int unsigned cand;

    always_comb begin
        found = 1'b0;
        idx   = '0;
        cand  = 0;
        for (int unsigned i = 0; i < N; i++) begin
            // ptr is always < N, so a single subtraction gives the modulo
            cand = 32'(ptr) + i;
            if (cand >= N) begin
                cand = cand - N;
            end
            if (!found && req[cand[IDX_W-1:0]]) begin
                found = 1'b1;
                idx   = cand[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/s2mm_packet_arbiter.sv
// s2mm_packet_arbiter: merges NUM_FIFOS first-word-fall-through FIFOs into a single
// AXI Stream, one whole packet at a time, round-robin between packets.
//   clk, rstn           clock, asynchronous active-low reset
//   fifo_rden_out       per-FIFO pop (combinational)
//   fifo_empty_in       per-FIFO empty flag
//   fifo_data_in        FIFO i data on slice i*FIFO_DATA_WIDTH
//   pkt_len_in          packet length in beats (0 treated as 1), sampled at grant
//   DST_AXIS_*          registered output stream; tdest carries the source index
//   pkt_count_out       per-source completed-packet counters (only with S2MM_PKT_COUNT_EN)
module s2mm_packet_arbiter
    import s2mm_pkg::*;
#(
    parameter int AXIS_DATA_WIDTH = 32,
    parameter int FIFO_DATA_WIDTH = 32,
    parameter int AXIS_DEST_WIDTH = 4,
    parameter int NUM_FIFOS       = 2,
    parameter int PKT_LEN_WIDTH   = 16
) (
    input  logic                                 clk,
    input  logic                                 rstn,
    output logic [NUM_FIFOS-1:0]                 fifo_rden_out,
    input  logic [NUM_FIFOS-1:0]                 fifo_empty_in,
    input  logic [FIFO_DATA_WIDTH*NUM_FIFOS-1:0] fifo_data_in,
    input  logic [PKT_LEN_WIDTH-1:0]             pkt_len_in,
    output logic [AXIS_DATA_WIDTH-1:0]           DST_AXIS_tdata_out,
    output logic [AXIS_DEST_WIDTH-1:0]           DST_AXIS_tdest_out,
    output logic                                 DST_AXIS_tlast_out,
    output logic                                 DST_AXIS_tvalid_out,
    input  logic                                 DST_AXIS_tready_in
`ifdef S2MM_PKT_COUNT_EN
    ,
    output logic [COUNT_WIDTH*NUM_FIFOS-1:0]     pkt_count_out
`endif
);

    localparam int IDX_W = idx_width(NUM_FIFOS);

    state_t                     state;
    logic [IDX_W-1:0]           grant;
    logic [IDX_W-1:0]           rr_ptr;
    logic [IDX_W-1:0]           next_ptr;
    logic [IDX_W-1:0]           arb_idx;
    logic                       arb_found;
    logic [PKT_LEN_WIDTH-1:0]   len;
    logic [PKT_LEN_WIDTH-1:0]   beat_cnt;
    logic                       out_free;
    logic                       pop;
    logic                       is_last;
    logic [FIFO_DATA_WIDTH-1:0] sel_data;

    rr_arbiter #(
        .NUM_FIFOS (NUM_FIFOS),
        .IDX_W     (IDX_W)
    ) u_arb (
        .req   (~fifo_empty_in),
        .ptr   (rr_ptr),
        .found (arb_found),
        .idx   (arb_idx)
    );

    assign out_free = !DST_AXIS_tvalid_out || DST_AXIS_tready_in;
    assign pop      = (state == XFER) && out_free && !fifo_empty_in[grant];
    assign is_last  = (beat_cnt == len - 1'b1);
    assign next_ptr = (32'(grant) == NUM_FIFOS - 1) ? '0 : grant + 1'b1;

    always_comb begin
        sel_data = '0;
        for (int unsigned i = 0; i < NUM_FIFOS; i++) begin
            if (32'(grant) == i) begin
                sel_data = fifo_data_in[i*FIFO_DATA_WIDTH +: FIFO_DATA_WIDTH];
            end
        end
    end

    always_comb begin
        fifo_rden_out = '0;
        if (pop) begin
            fifo_rden_out[grant] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state               <= IDLE;
            grant               <= '0;
            rr_ptr              <= '0;
            len                 <= '0;
            beat_cnt            <= '0;
            DST_AXIS_tdata_out  <= '0;
            DST_AXIS_tdest_out  <= '0;
            DST_AXIS_tlast_out  <= 1'b0;
            DST_AXIS_tvalid_out <= 1'b0;
        end else begin
            // Output register: load on pop, otherwise empty it once the beat has gone.
            // This also drains the final beat while IDLE is already re-arbitrating.
            if (pop) begin
                DST_AXIS_tdata_out  <= AXIS_DATA_WIDTH'(sel_data);
                DST_AXIS_tdest_out  <= AXIS_DEST_WIDTH'(grant);
                DST_AXIS_tlast_out  <= is_last;
                DST_AXIS_tvalid_out <= 1'b1;
            end else if (out_free) begin
                DST_AXIS_tvalid_out <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (arb_found) begin
                        grant    <= arb_idx;
                        len      <= (pkt_len_in == '0) ? PKT_LEN_WIDTH'(1) : pkt_len_in;
                        beat_cnt <= '0;
                        state    <= XFER;
                    end
                end
                XFER: begin
                    if (pop) begin
                        beat_cnt <= beat_cnt + 1'b1;
                        if (is_last) begin
                            state  <= IDLE;
                            rr_ptr <= next_ptr;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef S2MM_PKT_COUNT_EN
    logic [COUNT_WIDTH-1:0] pkt_cnt [NUM_FIFOS];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int unsigned i = 0; i < NUM_FIFOS; i++) begin
                pkt_cnt[i] <= '0;
            end
        end else if (DST_AXIS_tvalid_out && DST_AXIS_tready_in && DST_AXIS_tlast_out) begin
            for (int unsigned i = 0; i < NUM_FIFOS; i++) begin
                if (DST_AXIS_tdest_out == AXIS_DEST_WIDTH'(i)) begin
                    pkt_cnt[i] <= pkt_cnt[i] + 1'b1;
                end
            end
        end
    end

    always_comb begin
        pkt_count_out = '0;
        for (int unsigned i = 0; i < NUM_FIFOS; i++) begin
            pkt_count_out[i*COUNT_WIDTH +: COUNT_WIDTH] = pkt_cnt[i];
        end
    end
`endif

endmodule
